exception_sequencer: RTL

- Sequences exception and interrupt entry and return for the LEGv8 pipeline.
- Inputs: the decoder's synchronous exception flag and EStatus code, and round-robin arbitrated external IRQ lines.
- Actions: captures ELR/ESR/IRQ-id, flushes the pipeline, redirects fetch to the handler vector, handles the ERet return path.
- Detects a double fault (exception while in the handler) and halts.

---
 rtl/exception_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/exception_sequencer.sv
// Exception / interrupt entry and return sequencer for the LEGv8 pipeline.
// Captures ELR/ESR/IRQ id, flushes and redirects fetch, and halts on a double fault.
module exception_sequencer #(
  parameter int          PC_W   = 64,
  parameter int          N_IRQ  = 4,
  parameter logic [63:0] VECTOR = 64'hD8,
  localparam int         ID_W   = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exc_in,
  input  logic [3:0]       estatus_in,
  input  logic             eret_in,
  input  logic             valid_in,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [N_IRQ-1:0] irq_req,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             flush,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  elr,
  output logic [3:0]       esr,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_handler,
  output logic             halted
);

  // state   | meaning
  // IDLE    | normal execution, sampling sync exceptions and IRQs
  // ENTER   | one cycle: flush + redirect to the handler vector
  // HANDLER | executing handler code, IRQs masked
  // RETURN  | one cycle: flush + redirect to elr
  // FAULT   | double fault, halted until reset
  typedef enum logic [2:0] {IDLE, ENTER, HANDLER, RETURN, FAULT} state_t;

  localparam logic [PC_W-1:0] VEC_PC = PC_W'(VECTOR);

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  grant_nxt;
  logic [N_IRQ-1:0] grant_oh;
  logic             found;
  logic             sync_evt;
  logic             eret_evt;

  assign sync_evt = exc_in & valid_in;
  assign eret_evt = eret_in & valid_in;

  // Round-robin search starting at rr_ptr, wrapping to 0.
  always_comb begin
    found     = 1'b0;
    grant_idx = rr_ptr;
    for (int i = 0; i < N_IRQ; i++) begin
      if (!found && irq_req[(int'(rr_ptr) + i) % N_IRQ]) begin
        found     = 1'b1;
        grant_idx = ID_W'((int'(rr_ptr) + i) % N_IRQ);
      end
    end
    grant_nxt = (grant_idx == ID_W'(N_IRQ - 1)) ? '0 : grant_idx + ID_W'(1);
    grant_oh  = N_IRQ'(1) << grant_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      irq_ack     <= '0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      elr         <= '0;
      esr         <= '0;
      irq_id      <= '0;
      in_handler  <= 1'b0;
      halted      <= 1'b0;
    end else begin
      irq_ack  <= '0;
      flush    <= 1'b0;
      redirect <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_evt || found) begin
            state       <= ENTER;
            elr         <= pc_in;
            flush       <= 1'b1;
            redirect    <= 1'b1;
            redirect_pc <= VEC_PC;
            in_handler  <= 1'b1;
            if (sync_evt) begin
              esr <= estatus_in;
            end else begin
              esr     <= 4'b0001;
              irq_id  <= grant_idx;
              irq_ack <= grant_oh;
              rr_ptr  <= grant_nxt;
            end
          end
        end
        ENTER: state <= HANDLER;
        HANDLER: begin
          if (sync_evt) begin
            state  <= FAULT;
            halted <= 1'b1;
            flush  <= 1'b1;
          end else if (eret_evt) begin
            state       <= RETURN;
            flush       <= 1'b1;
            redirect    <= 1'b1;
            redirect_pc <= elr;
            in_handler  <= 1'b0;
          end
        end
        RETURN: state <= IDLE;
        FAULT:  flush <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
